// File: rtl/dmem_responder.sv
// dmem_responder: cycle-accurate main-memory responder for the data cache.
// Accepts single reads, single writes and aligned line fills. Returns the
// first beat (or the write ack) LATENCY+1 edges after the accepting edge.
module dmem_responder #(
   parameter int DEPTH     = 16384,
   parameter int LATENCY   = 4,
   parameter int BURST_LEN = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] mem_address,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_burst,
   input  logic [31:0] mem_wdata,
   output logic        mem_busy,
   output logic [31:0] mem_rdata,
   output logic        mem_rvalid,
   output logic        mem_last,
   output logic        mem_ack,
   output logic        mem_err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [AW-1:0] LINE_MASK = AW'(BURST_LEN - 1);
   localparam logic [BW:0]   LAST_BEAT = (BW+1)'(BURST_LEN - 1);
   localparam logic [7:0]    LAT_LOAD  = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RBEAT, WCOMMIT} state_t;

   // Registered request; only the word index inside the store is kept.
   typedef struct packed {
      logic [AW-1:0] idx;
      logic [31:0]   wdata;
      logic          burst;
      logic          is_write;
   } req_t;

   state_t        state, state_d;
   req_t          req, req_d;
   logic [7:0]    cnt, cnt_d;
   logic [BW:0]   beat, beat_d;
   logic          rvalid_d, last_d, ack_d, err_d, we;
   logic [AW-1:0] rd_idx;
   logic [31:0]   store [DEPTH];

   // Address bits above the store index alias and are intentionally dropped.
   logic addr_hi_unused;
   assign addr_hi_unused = ^mem_address[31:AW];

   // Busy covers the response cycle too, so a new request lands one cycle
   // after the final beat / ack.
   assign mem_busy = (state != IDLE) | mem_rvalid | mem_ack;

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state;
      req_d    = req;
      cnt_d    = cnt;
      beat_d   = beat;
      rvalid_d = 1'b0;
      last_d   = 1'b0;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      we       = 1'b0;
      rd_idx   = req.idx;
      unique case (state)
         IDLE: begin
            if (!mem_busy) begin
               if (mem_read && mem_write) begin
                  err_d = 1'b1;
               end else if (mem_read || mem_write) begin
                  req_d.idx      = mem_address[AW-1:0];
                  req_d.wdata    = mem_wdata;
                  req_d.burst    = mem_burst & mem_read;
                  req_d.is_write = mem_write;
                  cnt_d          = LAT_LOAD;
                  beat_d         = '0;
                  state_d        = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) state_d = req.is_write ? WCOMMIT : RBEAT;
            else           cnt_d   = cnt - 1'b1;
         end
         RBEAT: begin
            rvalid_d = 1'b1;
            if (req.burst) begin
               // Line fills always start at the line base, whatever the offset.
               rd_idx = (req.idx & ~LINE_MASK) | AW'(beat[BW-1:0]);
               last_d = (beat == LAST_BEAT);
            end else begin
               last_d = 1'b1;
            end
            if (last_d) begin
               state_d = IDLE;
               beat_d  = '0;
            end else begin
               beat_d  = beat + 1'b1;
            end
         end
         WCOMMIT: begin
            we      = 1'b1;
            ack_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and registered response outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         req        <= '0;
         cnt        <= '0;
         beat       <= '0;
         mem_rvalid <= 1'b0;
         mem_last   <= 1'b0;
         mem_ack    <= 1'b0;
         mem_err    <= 1'b0;
         mem_rdata  <= '0;
      end else begin
         state      <= state_d;
         req        <= req_d;
         cnt        <= cnt_d;
         beat       <= beat_d;
         mem_rvalid <= rvalid_d;
         mem_last   <= last_d;
         mem_ack    <= ack_d;
         mem_err    <= err_d;
         if (rvalid_d) mem_rdata <= store[rd_idx];
      end
   end

   // Backing store; contents survive reset.
   always_ff @(posedge clock) begin
      if (we) store[req.idx] <= req.wdata;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, hand-written reset/drop sequences and
// randomized traffic checked against a word-array memory model.
module tb_dmem_responder;
   localparam int DEPTH     = 16384;
   localparam int LATENCY   = 4;
   localparam int BURST_LEN = 64;
   localparam int AW        = $clog2(DEPTH);
   localparam int MAXN      = LATENCY + BURST_LEN + 8;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] mem_address = '0;
   logic        mem_read = 1'b0, mem_write = 1'b0, mem_burst = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic        mem_busy, mem_rvalid, mem_last, mem_ack, mem_err;
   logic [31:0] mem_rdata;

   always #5 clock = ~clock;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BURST_LEN(BURST_LEN)) dut (
      .clock(clock), .reset_n(reset_n), .mem_address(mem_address),
      .mem_read(mem_read), .mem_write(mem_write), .mem_burst(mem_burst),
      .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .mem_last(mem_last), .mem_ack(mem_ack),
      .mem_err(mem_err));

   int checks = 0;
   int errors = 0;
   logic [31:0] model [DEPTH];

   // Results of the most recent request.
   bit          r_err0, r_busy0, r_ack, r_err, r_busy_hold, r_busy_after;
   int          r_lat, r_nbeats, r_nlast, r_lastpos;
   logic [31:0] r_data [$];

   typedef struct {
      string       name;
      bit          rd, wr, bst;
      logic [31:0] addr, wdata;
      bit          exp_err, exp_ack, exp_beat;
      logic [31:0] exp_data;
   } vec_t;
   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] widx(input logic [31:0] a);
      return AW'(a % 32'(DEPTH));
   endfunction

   task automatic issue(input bit rd, input bit wr, input bit bst,
                        input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      mem_read = rd; mem_write = wr; mem_burst = bst; mem_address = a; mem_wdata = d;
      @(posedge clock); #1;
      r_err0 = mem_err; r_busy0 = mem_busy;
      mem_read = 1'b0; mem_write = 1'b0; mem_burst = 1'b0;
      mem_address = $urandom; mem_wdata = $urandom;
   endtask

   // Watch edges 1..maxn after acceptance; stop one sample after the end.
   task automatic collect(input int maxn);
      int n_end;
      n_end = -1;
      r_lat = -1; r_nbeats = 0; r_nlast = 0; r_lastpos = -1;
      r_ack = 1'b0; r_err = 1'b0; r_busy_hold = 1'b1; r_busy_after = 1'b1;
      r_data.delete();
      for (int n = 1; n <= maxn; n++) begin
         @(posedge clock); #1;
         if (n_end >= 0) begin
            r_busy_after = mem_busy;
            break;
         end
         if (!mem_busy) r_busy_hold = 1'b0;
         if (mem_err) r_err = 1'b1;
         if (mem_rvalid) begin
            if (r_lat < 0) r_lat = n;
            r_data.push_back(mem_rdata);
            if (mem_last) begin
               r_nlast++;
               r_lastpos = r_nbeats;
               n_end = n;
            end
            r_nbeats++;
         end
         if (mem_ack) begin
            if (r_lat < 0) r_lat = n;
            r_ack = 1'b1;
            n_end = n;
         end
      end
   endtask

   // Full request with every response property compared against the model.
   task automatic do_req(input string tag, input bit rd, input bit wr, input bit bst,
                         input logic [31:0] a, input logic [31:0] d);
      logic [31:0] base;
      int nexp;
      issue(rd, wr, bst, a, d);
      if (rd && wr) begin
         check({tag, " err_pulse"}, r_err0, 1);
         check({tag, " err_busy"}, r_busy0, 0);
         collect(LATENCY + 3);
         check({tag, " err_width"}, r_err, 0);
         check({tag, " err_no_resp"}, r_nbeats + int'(r_ack), 0);
         return;
      end
      check({tag, " busy_after_accept"}, r_busy0, 1);
      collect(MAXN);
      check({tag, " latency"}, r_lat, LATENCY + 1);
      check({tag, " busy_hold"}, r_busy_hold, 1);
      check({tag, " busy_drop"}, r_busy_after, 0);
      check({tag, " spurious_err"}, r_err, 0);
      if (wr) begin
         check({tag, " ack"}, r_ack, 1);
         check({tag, " write_beats"}, r_nbeats, 0);
         model[widx(a)] = d;
      end else begin
         nexp = bst ? BURST_LEN : 1;
         base = bst ? (a / 32'(BURST_LEN)) * 32'(BURST_LEN) : a;
         check({tag, " beats"}, r_nbeats, nexp);
         check({tag, " nlast"}, r_nlast, 1);
         check({tag, " last_pos"}, r_lastpos, nexp - 1);
         for (int i = 0; i < r_data.size() && i < nexp; i++)
            check($sformatf("%s beat%0d", tag, i), r_data[i], model[widx(base + 32'(i))]);
      end
   endtask

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int cnt;
      logic [31:0] a, d, old21, old22;
      tbl[0] = '{"wr10",   0, 1, 0, 32'h10,   32'hDEADBEEF, 0, 1, 0, 32'h0};
      tbl[1] = '{"rd10",   1, 0, 0, 32'h10,   32'h0,        0, 0, 1, 32'hDEADBEEF};
      tbl[2] = '{"wr4005", 0, 1, 0, 32'h4005, 32'h55,       0, 1, 0, 32'h0};
      tbl[3] = '{"rd5",    1, 0, 0, 32'h5,    32'h0,        0, 0, 1, 32'h55};
      tbl[4] = '{"rw10",   1, 1, 0, 32'h10,   32'h1234,     1, 0, 0, 32'h0};
      tbl[5] = '{"rd10b",  1, 0, 0, 32'h10,   32'h0,        0, 0, 1, 32'hDEADBEEF};
      tbl[6] = '{"wrbst",  0, 1, 1, 32'h30,   32'h33,       0, 1, 0, 32'h0};
      tbl[7] = '{"rd30",   1, 0, 0, 32'h30,   32'h0,        0, 0, 1, 32'h33};

      // Reset held for three cycles.
      repeat (3) @(negedge clock);
      check("rst busy", mem_busy, 0);
      check("rst rvalid", mem_rvalid, 0);
      check("rst last", mem_last, 0);
      check("rst ack", mem_ack, 0);
      check("rst err", mem_err, 0);
      check("rst rdata", mem_rdata, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      check("rst release busy", mem_busy, 0);

      // Give words 0..255 known contents.
      for (int i = 0; i < 256; i++) do_req("pre", 0, 1, 0, 32'(i), $urandom);

      // Table-driven directed vectors.
      foreach (tbl[k]) begin
         issue(tbl[k].rd, tbl[k].wr, tbl[k].bst, tbl[k].addr, tbl[k].wdata);
         check({tbl[k].name, " err"}, r_err0, tbl[k].exp_err);
         collect(tbl[k].exp_err ? LATENCY + 3 : MAXN);
         check({tbl[k].name, " ack"}, r_ack, tbl[k].exp_ack);
         check({tbl[k].name, " nbeats"}, r_nbeats, tbl[k].exp_beat ? 1 : 0);
         if (tbl[k].exp_ack || tbl[k].exp_beat) check({tbl[k].name, " latency"}, r_lat, LATENCY + 1);
         if (tbl[k].exp_beat) begin
            check({tbl[k].name, " data"}, (r_data.size() > 0) ? r_data[0] : 32'hx, tbl[k].exp_data);
            check({tbl[k].name, " last"}, r_nlast, 1);
         end
         if (tbl[k].exp_ack) model[widx(tbl[k].addr)] = tbl[k].wdata;
      end

      // Unaligned line fill over a preloaded line.
      for (int i = 0; i < 64; i++) do_req("pre_line", 0, 1, 0, 32'(64 + i), 32'h1000 + 32'(i));
      do_req("burst5A", 1, 0, 1, 32'h5A, 32'h0);
      check("burst5A first", (r_data.size() > 0) ? r_data[0] : 32'hx, 32'h1000);
      check("burst5A last_data", (r_data.size() == 64) ? r_data[63] : 32'hx, 32'h103F);

      // Request held throughout a busy write is dropped.
      old22 = model[8'h22];
      d = $urandom;
      issue(0, 1, 0, 32'h21, d);
      mem_write = 1'b1; mem_address = 32'h22; mem_wdata = ~old22;
      collect(MAXN);
      mem_write = 1'b0;
      check("drop latency", r_lat, LATENCY + 1);
      check("drop busy_drop", r_busy_after, 0);
      model[8'h21] = d;
      do_req("drop rd22", 1, 0, 0, 32'h22, 32'h0);
      do_req("drop rd21", 1, 0, 0, 32'h21, 32'h0);

      // Reset pulsed during WAIT of a write.
      issue(0, 1, 0, 32'h20, 32'h77);
      repeat (2) begin @(posedge clock); #1; end
      reset_n = 1'b0; #1;
      check("rstw busy", mem_busy, 0);
      check("rstw ack", mem_ack, 0);
      @(negedge clock); reset_n = 1'b1;
      cnt = 0;
      for (int n = 0; n < LATENCY + 4; n++) begin
         @(posedge clock); #1;
         if (mem_ack || mem_busy) cnt++;
      end
      check("rstw no_ack", cnt, 0);
      do_req("rstw rd20", 1, 0, 0, 32'h20, 32'h0);

      // Reset pulsed at beat 10 of a burst.
      issue(1, 0, 1, 32'h40, 32'h0);
      cnt = 0;
      for (int n = 0; n < MAXN && cnt < 11; n++) begin
         @(posedge clock); #1;
         if (mem_rvalid) cnt++;
      end
      check("rstb reached beat10", cnt, 11);
      reset_n = 1'b0; #1;
      check("rstb rvalid", mem_rvalid, 0);
      check("rstb busy", mem_busy, 0);
      check("rstb last", mem_last, 0);
      @(negedge clock); reset_n = 1'b1;
      cnt = 0;
      for (int n = 0; n < MAXN; n++) begin
         @(posedge clock); #1;
         if (mem_rvalid || mem_busy) cnt++;
      end
      check("rstb quiet", cnt, 0);

      // Randomized traffic, addresses aliased through the upper bits.
      for (int it = 0; it < 200; it++) begin
         a = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 255));
         cnt = $urandom_range(0, 9);
         if (cnt <= 3)      do_req($sformatf("rnd%0d wr", it), 0, 1, 1'($urandom_range(0, 1)), a, $urandom);
         else if (cnt <= 6) do_req($sformatf("rnd%0d rd", it), 1, 0, 0, a, $urandom);
         else if (cnt <= 8) do_req($sformatf("rnd%0d bst", it), 1, 0, 1, a, $urandom);
         else               do_req($sformatf("rnd%0d rw", it), 1, 1, 0, a, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
